// File: rtl/st_hazard_ctrl_pkg.sv
// rtl/st_hazard_ctrl_pkg.sv - shared constants for the pipeline hazard controller
//
// Purpose: forward-select encodings, Tuse/Tnew width, the "operand not read"
// code and the all-zero bubble loaded into the E shadow stage on a stall.
package st_pkg;

    localparam int TW = 3;

    // Tuse code for an operand the instruction does not read.
    localparam logic [TW-1:0] NO_USE = 3'b111;

    // Forward-mux select encodings.
    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;  // link value of a jal in E
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    // E shadow layout: {addr[4:0], tnew[TW-1:0], rs[4:0], rt[4:0]}.
    localparam int E_W = 15 + TW;
    // M shadow layout: {addr[4:0], tnew[TW-1:0], rt[4:0]}.
    localparam int M_W = 10 + TW;
    // W shadow layout: {addr[4:0]}.
    localparam int W_W = 5;

    // Bubble inserted into E when D stalls: no destination, no sources.
    localparam logic [E_W-1:0] E_BUBBLE = '0;

endpackage

// File: rtl/st_hazard_ctrl_if.sv
// rtl/st_hazard_ctrl_if.sv - D-stage decode in, stall and forward selects out
//
// Purpose: bundles the decode fields produced in D and the hazard outputs.
// Modports:
//   master - decode side: drives D_* fields, observes stall and fwd selects
//   slave  - hazard controller: reads D_* fields, drives stall and fwd selects
interface st_hazard_ctrl_if #(
    parameter int TW = st_pkg::TW
);
    logic [4:0]    D_rs;
    logic [4:0]    D_rt;
    logic [TW-1:0] D_rs_use;
    logic [TW-1:0] D_rt_use;
    logic [4:0]    D_grf_addr;
    logic [TW-1:0] D_tnew;
    logic          stall;
    logic [1:0]    D_fwd_rs;
    logic [1:0]    D_fwd_rt;
    logic [1:0]    E_fwd_rs;
    logic [1:0]    E_fwd_rt;
    logic [1:0]    M_fwd_rt;

    modport master (
        output D_rs, D_rt, D_rs_use, D_rt_use, D_grf_addr, D_tnew,
        input  stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt
    );

    modport slave (
        input  D_rs, D_rt, D_rs_use, D_rt_use, D_grf_addr, D_tnew,
        output stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt
    );
endinterface

// File: rtl/st_hazard_ctrl_shadow_reg.sv
// rtl/st_hazard_ctrl_shadow_reg.sv - one pipeline shadow stage register
//
// Purpose: holds one stage's hazard-relevant fields.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high, loads zero
//   clear  - synchronous bubble, loads CLR_VAL instead of d_in
//   d_in   - next stage contents
//   q_out  - current stage contents
module st_shadow_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = clear ? CLR_VAL : d_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_out = data_q;
endmodule

// File: rtl/st_hazard_ctrl.sv
// rtl/st_hazard_ctrl.sv - MIPS five-stage stall and forwarding controller
//
// Purpose: shadows destination/Tnew through E, M and W, raises the D stall
// when a source is needed before its producer can supply it, and selects the
// nearest ready producer for the D, E and M operand muxes.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high, clears all shadow state
//   hz    - slave modport: D decode fields in, stall and fwd selects out
module st_hazard_ctrl
    import st_pkg::FWD_GRF, st_pkg::FWD_E, st_pkg::FWD_M, st_pkg::FWD_W;
    import st_pkg::E_W, st_pkg::M_W, st_pkg::W_W, st_pkg::E_BUBBLE;
#(
    parameter int            TW     = st_pkg::TW,
    parameter logic [TW-1:0] NO_USE = st_pkg::NO_USE
)(
    input  logic              clk,
    input  logic              reset,
    st_hazard_ctrl_if.slave   hz
);
    logic [E_W-1:0] e_d, e_q;
    logic [M_W-1:0] m_d, m_q;
    logic [W_W-1:0] w_d, w_q;

    logic [4:0]    e_addr, e_rs, e_rt, m_addr, m_rt, w_addr;
    logic [TW-1:0] e_tnew, m_tnew, e_tnew_dec;
    logic          rs_conflict, rt_conflict, stall;

    assign {e_addr, e_tnew, e_rs, e_rt} = e_q;
    assign {m_addr, m_tnew, m_rt}       = m_q;
    assign w_addr                       = w_q;

    // Source s with Tuse u must wait while a producer still needs more
    // cycles than u. $0 and NO_USE never wait; NO_USE exceeds any Tnew.
    function automatic logic conflict(input logic [4:0] s, input logic [TW-1:0] u,
                                      input logic [4:0] ea, input logic [TW-1:0] et,
                                      input logic [4:0] ma, input logic [TW-1:0] mt);
        return (s != 5'd0) && (u != NO_USE) &&
               (((ea == s) && (u < et)) || ((ma == s) && (u < mt)));
    endfunction

    always_comb begin
        rs_conflict = conflict(hz.D_rs, hz.D_rs_use, e_addr, e_tnew, m_addr, m_tnew);
        rt_conflict = conflict(hz.D_rt, hz.D_rt_use, e_addr, e_tnew, m_addr, m_tnew);
        stall       = rs_conflict | rt_conflict;
    end

    // Tnew counts down one per stage and saturates at zero.
    always_comb begin
        e_tnew_dec = (e_tnew == '0) ? '0 : e_tnew - TW'(1);
        e_d        = {hz.D_grf_addr, hz.D_tnew, hz.D_rs, hz.D_rt};
        m_d        = {e_addr, e_tnew_dec, e_rt};
        w_d        = m_addr;
    end

    st_shadow_reg #(.W(E_W), .CLR_VAL(E_BUBBLE)) u_e_stage (
        .clk(clk), .reset(reset), .clear(stall), .d_in(e_d), .q_out(e_q)
    );
    st_shadow_reg #(.W(M_W)) u_m_stage (
        .clk(clk), .reset(reset), .clear(1'b0), .d_in(m_d), .q_out(m_q)
    );
    st_shadow_reg #(.W(W_W)) u_w_stage (
        .clk(clk), .reset(reset), .clear(1'b0), .d_in(w_d), .q_out(w_q)
    );

    // Nearest ready producer wins; W always has Tnew 0.
    function automatic logic [1:0] fwd_d(input logic [4:0] s);
        if (s == 5'd0)                            return FWD_GRF;
        else if ((e_addr == s) && (e_tnew == '0)) return FWD_E;
        else if ((m_addr == s) && (m_tnew == '0)) return FWD_M;
        else if (w_addr == s)                     return FWD_W;
        else                                      return FWD_GRF;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] s);
        if (s == 5'd0)                            return FWD_GRF;
        else if ((m_addr == s) && (m_tnew == '0)) return FWD_M;
        else if (w_addr == s)                     return FWD_W;
        else                                      return FWD_GRF;
    endfunction

    always_comb begin
        hz.stall    = stall;
        hz.D_fwd_rs = fwd_d(hz.D_rs);
        hz.D_fwd_rt = fwd_d(hz.D_rt);
        hz.E_fwd_rs = fwd_e(e_rs);
        hz.E_fwd_rt = fwd_e(e_rt);
        hz.M_fwd_rt = ((m_rt != 5'd0) && (w_addr == m_rt)) ? FWD_W : FWD_GRF;
    end
endmodule

// File: tb/tb_st_hazard_ctrl.sv
// tb/tb_st_hazard_ctrl.sv - scoreboard bench for st_hazard_ctrl
module tb_st_hazard_ctrl;

    logic clk;
    logic reset;

    st_hazard_ctrl_if #(.TW(3)) hz ();

    st_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       stall;
        logic [1:0] dfr;
        logic [1:0] dft;
        logic [1:0] efr;
        logic [1:0] eft;
        logic [1:0] mfr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    localparam logic [2:0] NU = 3'd7;

    task automatic cmp(input string nm, input string fld, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    // Monitor: DUT outputs are valid every cycle; compare on the falling edge
    // whenever the stimulus has queued an expectation for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "stall",    {1'b0, hz.stall}, {1'b0, e.stall});
            cmp(e.name, "D_fwd_rs", hz.D_fwd_rs, e.dfr);
            cmp(e.name, "D_fwd_rt", hz.D_fwd_rt, e.dft);
            cmp(e.name, "E_fwd_rs", hz.E_fwd_rs, e.efr);
            cmp(e.name, "E_fwd_rt", hz.E_fwd_rt, e.eft);
            cmp(e.name, "M_fwd_rt", hz.M_fwd_rt, e.mfr);
        end
    end

    // Apply one D-stage instruction for one cycle and queue its expected outputs.
    task automatic v(input string nm, input logic rst,
                     input logic [4:0] rs, input logic [2:0] rsu,
                     input logic [4:0] rt, input logic [2:0] rtu,
                     input logic [4:0] dst, input logic [2:0] tn,
                     input logic st, input logic [1:0] dfr, input logic [1:0] dft,
                     input logic [1:0] efr, input logic [1:0] eft, input logic [1:0] mfr);
        exp_t e;
        reset         = rst;
        hz.D_rs       = rs;
        hz.D_rs_use   = rsu;
        hz.D_rt       = rt;
        hz.D_rt_use   = rtu;
        hz.D_grf_addr = dst;
        hz.D_tnew     = tn;
        e.name = nm; e.stall = st; e.dfr = dfr; e.dft = dft;
        e.efr = efr; e.eft = eft; e.mfr = mfr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string nm, input logic [1:0] efr, input logic [1:0] eft, input logic [1:0] mfr);
        v(nm, 1'b0, 5'd0, NU, 5'd0, NU, 5'd0, 3'd0, 1'b0, 2'd0, 2'd0, efr, eft, mfr);
    endtask

    initial begin
        reset = 1'b1;
        hz.D_rs = 5'd0; hz.D_rs_use = NU; hz.D_rt = 5'd0; hz.D_rt_use = NU;
        hz.D_grf_addr = 5'd0; hz.D_tnew = 3'd0;
        @(posedge clk);
        #1;
        // Reset state: lw in D cannot match cleared shadow state.
        v("reset", 1'b1, 5'd3, 3'd1, 5'd1, NU, 5'd1, 3'd2, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        // lw $1 ; add $2,$1,$3 : one stall, then E_fwd_rs = W.
        v("lw_alu.lw",    1'b0, 5'd3, 3'd1, 5'd1, NU,   5'd1, 3'd2, 1'b0, 0, 0, 0, 0, 0);
        v("lw_alu.stall", 1'b0, 5'd1, 3'd1, 5'd3, 3'd1, 5'd2, 3'd1, 1'b1, 0, 0, 0, 0, 0);
        v("lw_alu.go",    1'b0, 5'd1, 3'd1, 5'd3, 3'd1, 5'd2, 3'd1, 1'b0, 0, 0, 0, 0, 0);
        nop("lw_alu.e", 2'd3, 2'd0, 2'd0);
        nop("lw_alu.f1", 2'd0, 2'd0, 2'd0);
        nop("lw_alu.f2", 2'd0, 2'd0, 2'd0);

        // lw $1 ; beq $1,$0 : two stalls, then D_fwd_rs = W.
        v("lw_beq.lw", 1'b0, 5'd3, 3'd1, 5'd1, NU,   5'd1, 3'd2, 1'b0, 0, 0, 0, 0, 0);
        v("lw_beq.s1", 1'b0, 5'd1, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 0, 0, 0, 0, 0);
        v("lw_beq.s2", 1'b0, 5'd1, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 0, 0, 0, 0, 0);
        v("lw_beq.go", 1'b0, 5'd1, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 3, 0, 0, 0, 0);
        nop("lw_beq.f1", 2'd0, 2'd0, 2'd0);

        // add $4,$5,$6 ; beq $4,$5 : one stall, then D_fwd_rs = M.
        v("alu_beq.add", 1'b0, 5'd5, 3'd1, 5'd6, 3'd1, 5'd4, 3'd1, 1'b0, 0, 0, 0, 0, 0);
        v("alu_beq.s1",  1'b0, 5'd4, 3'd0, 5'd5, 3'd0, 5'd0, 3'd0, 1'b1, 0, 0, 0, 0, 0);
        v("alu_beq.go",  1'b0, 5'd4, 3'd0, 5'd5, 3'd0, 5'd0, 3'd0, 1'b0, 2, 0, 0, 0, 0);
        nop("alu_beq.e", 2'd3, 2'd0, 2'd0);
        nop("alu_beq.f1", 2'd0, 2'd0, 2'd0);

        // jal ; jr $31 : no stall, D_fwd_rs = E.
        v("jal_jr.jal", 1'b0, 5'd0,  NU,   5'd0, NU, 5'd31, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        v("jal_jr.jr",  1'b0, 5'd31, 3'd0, 5'd0, NU, 5'd0,  3'd0, 1'b0, 1, 0, 0, 0, 0);
        nop("jal_jr.e", 2'd2, 2'd0, 2'd0);
        nop("jal_jr.f1", 2'd0, 2'd0, 2'd0);

        // ori $0,$1,5 ; add $2,$0,$0 : $0 never stalls or forwards.
        v("zero.ori", 1'b0, 5'd1, 3'd1, 5'd0, NU,   5'd0, 3'd1, 1'b0, 0, 0, 0, 0, 0);
        v("zero.add", 1'b0, 5'd0, 3'd1, 5'd0, 3'd1, 5'd2, 3'd1, 1'b0, 0, 0, 0, 0, 0);
        nop("zero.f1", 2'd0, 2'd0, 2'd0);
        nop("zero.f2", 2'd0, 2'd0, 2'd0);
        nop("zero.f3", 2'd0, 2'd0, 2'd0);

        // lw $1 ; add $1,$2,$3 ; add $5,$1,$0 : consumer in E picks M over W.
        v("prio.lw",   1'b0, 5'd3, 3'd1, 5'd1, NU,   5'd1, 3'd2, 1'b0, 0, 0, 0, 0, 0);
        v("prio.add1", 1'b0, 5'd2, 3'd1, 5'd3, 3'd1, 5'd1, 3'd1, 1'b0, 0, 0, 0, 0, 0);
        v("prio.add5", 1'b0, 5'd1, 3'd1, 5'd0, 3'd1, 5'd5, 3'd1, 1'b0, 0, 0, 0, 0, 0);
        nop("prio.e", 2'd2, 2'd0, 2'd0);
        nop("prio.f1", 2'd0, 2'd0, 2'd0);
        nop("prio.f2", 2'd0, 2'd0, 2'd0);

        // jal ; jal ; jr $31 : D consumer picks E over M.
        v("prio_d.jal1", 1'b0, 5'd0,  NU,   5'd0, NU, 5'd31, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        v("prio_d.jal2", 1'b0, 5'd0,  NU,   5'd0, NU, 5'd31, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        v("prio_d.jr",   1'b0, 5'd31, 3'd0, 5'd0, NU, 5'd0,  3'd0, 1'b0, 1, 0, 0, 0, 0);
        nop("prio_d.e", 2'd2, 2'd0, 2'd0);
        nop("prio_d.f1", 2'd0, 2'd0, 2'd0);

        // add $1 ; sw $1,0($2) : E_fwd_rt = M, then M_fwd_rt = W.
        v("sw.add", 1'b0, 5'd2, 3'd1, 5'd3, 3'd1, 5'd1, 3'd1, 1'b0, 0, 0, 0, 0, 0);
        v("sw.sw",  1'b0, 5'd2, 3'd1, 5'd1, 3'd2, 5'd0, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        nop("sw.e", 2'd0, 2'd2, 2'd0);
        nop("sw.m", 2'd0, 2'd0, 2'd3);

        // Reset asserted during a lw -> beq stall clears it on that edge.
        v("rst.lw",   1'b0, 5'd3, 3'd1, 5'd1, NU,   5'd1, 3'd2, 1'b0, 0, 0, 0, 0, 0);
        v("rst.s1",   1'b0, 5'd1, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 0, 0, 0, 0, 0);
        v("rst.hold", 1'b1, 5'd1, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b1, 0, 0, 0, 0, 0);
        v("rst.after",1'b0, 5'd1, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        nop("rst.f1", 2'd0, 2'd0, 2'd0);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 2000) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/st_hazard_ctrl.md
# st_hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It consumes the per-instruction decode produced in D (source registers, Tuse for rs/rt, destination GRF address, Tnew at E) and keeps its own E/M/W shadow of destination address and remaining Tnew. From these it derives the D-stage stall and all forwarding-mux selects. It sits beside the D/E, E/M and M/W pipeline registers and steers the D-, E- and M-stage operand muxes.

## Interface
Parameters:
- `TW`, 3: width of Tuse/Tnew fields.
- `NO_USE`, 3'b111: Tuse code meaning "operand not read"; never causes a stall.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all shadow state.
- `D_rs`, `D_rt` in 5: D-stage source register numbers.
- `D_rs_use`, `D_rt_use` in TW: cycles until the operand is needed, measured from D. 0 = beq/jr, 1 = ALU, 2 = sw rt, NO_USE = not read.
- `D_grf_addr` in 5: D-stage destination. 0 = no write.
- `D_tnew` in TW: Tnew when the instruction is in E (add/sub/ori/lui 1, lw 2, jal 0).
- `stall` out 1: freeze PC and F/D, bubble D/E.
- `D_fwd_rs`, `D_fwd_rt` out 2: D comparator/jr operand source.
- `E_fwd_rs`, `E_fwd_rt` out 2: ALU operand source.
- `M_fwd_rt` out 2: DM write-data source.

## Operation
Forward encodings (package constants):
- FWD_GRF = 0
- FWD_E = 1 (link value of a jal sitting in E)
- FWD_M = 2
- FWD_W = 3

State (registered):
- E stage: `E_addr`, `E_tnew`, `E_rs`, `E_rt`.
- M stage: `M_addr`, `M_tnew`, `M_rt`.
- W stage: `W_addr`.

Stall, combinational:
- A source with address `s` and Tuse `u` is considered only when `s != 0` and `u != NO_USE`.
- It conflicts when `E_addr == s && u < E_tnew`, or when `M_addr == s && u < M_tnew`.
- `stall` is the OR over the rs and rt conflicts.

Stage advance on every clock edge, not in reset:
- E: if `stall`, E is loaded with a bubble (all fields 0). Otherwise it loads `D_grf_addr`, `D_tnew`, `D_rs`, `D_rt`.
- M: loads E. `M_tnew = (E_tnew == 0) ? 0 : E_tnew - 1`, saturating, unsigned TW bits.
- W: loads `W_addr = M_addr`. Tnew in W is always 0.

Forward select for register `s` at a consuming stage, combinational:
- Priority is nearest producer first. Only producers with Tnew == 0 are eligible.
- D consumers: `E_addr == s && E_tnew == 0` gives FWD_E; else `M_addr == s && M_tnew == 0` gives FWD_M; else `W_addr == s` gives FWD_W; else FWD_GRF.
- E consumers (`E_rs`, `E_rt`): M (tnew 0), then W, else GRF.
- M consumer (`M_rt`): W, else GRF.
- `s == 0` always selects FWD_GRF.

Boundary rules:
- `$0` as destination never stalls or forwards.
- Same register written in both E and M: E wins, including when E stalls.
- Stall and bubble in the same cycle: M/W still advance.
- NO_USE (7) is never less than any Tnew (maximum 2), so it never stalls.

## Timing
- Reset: on a rising edge with `reset` = 1, all state is 0. Consequently `stall` = 0 and every fwd output = FWD_GRF from that edge on.
- Reset mid-stall clears the stall on the same edge.
- Outputs are purely combinational from the current D inputs and the registered state: zero-cycle latency.
- The stall length for a dependency is `max(0, Tnew_at_E - Tuse)` cycles:
  - lw→ALU: 1
  - lw→beq: 2
  - ALU→beq: 1
  - jal→jr: 0
- Inputs must hold stable while `stall` = 1; the upstream F/D register is frozen by that signal.

## Structure
- Package `st_pkg`: FWD_* encodings, NO_USE, TW, and the zero-bubble constant.
- Sub-module `st_shadow_reg`: stage register with `clk`, synchronous `reset`, synchronous `clear` (bubble), and data in/out. Instantiated for E, M and W.
- The top module holds the stall compare, the Tnew decrement and the forward priority logic.

## Test plan
- lw $1 in D, then add $2,$1,$3: exactly 1 stall cycle. When add is in E, `E_fwd_rs` = FWD_W.
- lw $1, then beq $1,$0: 2 stall cycles, then `D_fwd_rs` = FWD_W, `stall` = 0.
- add $4, then beq $4,$5: 1 stall. Next cycle `D_fwd_rs` = FWD_M.
- jal, then jr $31: `stall` = 0 and `D_fwd_rs` = FWD_E.
- ori $0,$1,5, then add $2,$0,$0: no stall, all fwd = FWD_GRF. Also add $1 in E with lw $1 in M: E wins.
- Assert `reset` during a lw→beq stall: on the next edge `stall` = 0 and all selects = FWD_GRF.
